// File: rtl/instr_encoder_loader_if.sv
// Tuple-in / imem-write-out bundle for the RV32I field-to-word encoder.
// The master side drives tuples and start; the slave side is the encoder.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    modport master (
        output start, in_valid, in_last, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_last, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
        output in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I field-to-word encoder: range-checks each tuple, packs it into a
// 32-bit instruction and writes it to consecutive imem word addresses.
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic clk,
    input  logic rst_n,
    instr_encoder_loader_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+1:0] DEPTH_W2  = (ADDR_W+2)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        err_q, err_d;
    logic              wr_valid_q, wr_valid_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              last_pend_q, last_pend_d;

    logic [31:0]       word;
    logic              imm_ok;
    logic [31:0]       imm;
    logic [ADDR_W+1:0] fill;
    logic [ADDR_W:0]   count_inc;
    logic              in_ready;
    logic              accept;

    assign imm       = bus.imm;
    assign fill      = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, wr_valid_q};
    assign count_inc = count_q + CNT_ONE;
    // Words already pending count against DEPTH so the session never overshoots.
    assign in_ready  = (state_q == S_RUN) && !last_pend_q && (fill < DEPTH_W2);
    assign accept    = bus.in_valid && in_ready;

    always_comb begin
        word   = 32'd0;
        imm_ok = 1'b0;
        case (bus.fmt)
            3'd0: begin
                word   = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
                imm_ok = 1'b1;
            end
            3'd1: begin
                word   = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                imm_ok = (&imm[31:11]) || (~|imm[31:11]);
            end
            3'd2: begin
                word   = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
                imm_ok = (&imm[31:11]) || (~|imm[31:11]);
            end
            3'd3: begin
                word   = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                          imm[4:1], imm[11], bus.opcode};
                imm_ok = !imm[0] && ((&imm[31:12]) || (~|imm[31:12]));
            end
            3'd4: begin
                word   = {imm[31:12], bus.rd, bus.opcode};
                imm_ok = (imm[11:0] == 12'd0);
            end
            3'd5: begin
                word   = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
                imm_ok = !imm[0] && ((&imm[31:20]) || (~|imm[31:20]));
            end
            default: begin
                word   = 32'd0;
                imm_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        wr_valid_d  = 1'b0;
        wr_data_d   = wr_data_q;
        last_pend_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    ptr_d   = BASE_C;
                    count_d = '0;
                    err_d   = 2'b00;
                end
            end
            S_RUN: begin
                if (wr_valid_q) begin
                    ptr_d   = ptr_q + PTR_ONE;
                    count_d = count_inc;
                end
                if (accept) begin
                    wr_valid_d  = imm_ok;
                    wr_data_d   = word;
                    last_pend_d = bus.in_last;
                    if (!imm_ok) begin
                        err_d[0] = 1'b1;
                    end
                end
                // A pending last closes the session even if its tuple was rejected.
                if (last_pend_q) begin
                    state_d = S_DONE;
                end else if (wr_valid_q && (count_inc == DEPTH_C)) begin
                    err_d[1] = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= BASE_C;
            count_q     <= '0;
            err_q       <= 2'b00;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= 32'd0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            wr_valid_q  <= wr_valid_d;
            wr_data_q   <= wr_data_d;
            last_pend_q <= last_pend_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = wr_valid_q;
    assign bus.imem_addr  = ptr_q;
    assign bus.imem_wdata = wr_data_q;
    assign bus.count      = count_q;
    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: encoding vectors, latency, range errors, overflow
// (on a DEPTH=4 instance) and mid-session reset abort.
module tb_instr_encoder_loader;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    instr_encoder_loader_if #(.ADDR_W(10)) b ();
    instr_encoder_loader_if #(.ADDR_W(10)) b4 ();

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    logic [31:0] log_data[$];
    int          log_addr[$];
    int          log_cyc[$];
    int          log4_addr[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Writes are captured on the falling edge, clear of the active edge.
    always @(negedge clk) begin
        if (b.imem_we === 1'b1) begin
            log_data.push_back(b.imem_wdata);
            log_addr.push_back(int'(b.imem_addr));
            log_cyc.push_back(cyc);
        end
        if (b4.imem_we === 1'b1) begin
            log4_addr.push_back(int'(b4.imem_addr));
        end
    end

    task automatic idle_inputs();
        b.start = 0; b.in_valid = 0; b.in_last = 0; b.fmt = 0; b.opcode = 0;
        b.funct3 = 0; b.funct7 = 0; b.rd = 0; b.rs1 = 0; b.rs2 = 0; b.imm = 0;
        b4.start = 0; b4.in_valid = 0; b4.in_last = 0; b4.fmt = 0; b4.opcode = 0;
        b4.funct3 = 0; b4.funct7 = 0; b4.rd = 0; b4.rs1 = 0; b4.rs2 = 0; b4.imm = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
    endtask

    task automatic set_tuple(input logic [2:0] fmt, input logic [6:0] op,
                             input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm,
                             input logic last);
        b.fmt = fmt; b.opcode = op; b.funct3 = f3; b.funct7 = f7;
        b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm; b.in_last = last;
    endtask

    // Presents one tuple and returns #1 after the edge that accepted it.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic last);
        int t;
        t = 0;
        set_tuple(fmt, op, f3, f7, rd, rs1, rs2, imm, last);
        b.in_valid = 1'b1;
        while (b.in_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        n_checks++;
        if (t >= 50) begin
            n_fail++;
            $display("[TB] FAIL send_timeout in_ready got %b want 1", b.in_ready);
        end
        tick();
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
    endtask

    task automatic wait_done(output int pulses);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b.done === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (b.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", b.busy); end
        n_checks++;
        if (b.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", b.done); end
        n_checks++;
        if (b.err !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_err got %b want 00", b.err); end
        n_checks++;
        if (b.count !== 11'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", b.count); end
        n_checks++;
        if (b.imem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we got %b want 0", b.imem_we); end
        n_checks++;
        if (b.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 0", b.in_ready); end
        n_checks++;
        if (b.imem_addr !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_addr got %0d want 0", b.imem_addr); end
    endtask

    task automatic test_single();
        pulse_start();
        n_checks++;
        if (b.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL start_busy got %b want 1", b.busy); end
        n_checks++;
        if (b.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL start_ready got %b want 1", b.in_ready); end
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        n_checks++;
        if (b.imem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_we got %b want 1", b.imem_we); end
        n_checks++;
        if (b.imem_addr !== 10'd0) begin n_fail++; $display("[TB] FAIL addi_addr got %0d want 0", b.imem_addr); end
        n_checks++;
        if (b.imem_wdata !== 32'h00500093) begin n_fail++; $display("[TB] FAIL addi_word got %h want 00500093", b.imem_wdata); end
        n_checks++;
        if (b.count !== 11'd0) begin n_fail++; $display("[TB] FAIL addi_count_pre got %0d want 0", b.count); end
        tick();
        n_checks++;
        if (b.count !== 11'd1) begin n_fail++; $display("[TB] FAIL addi_count got %0d want 1", b.count); end
        n_checks++;
        if (b.imem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL addi_we_drop got %b want 0", b.imem_we); end
        pulse_start();
        n_checks++;
        if (b.count !== 11'd1 || b.busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL start_ignored count %0d busy %b want 1 1", b.count, b.busy);
        end
    endtask

    task automatic test_back_to_back();
        log_data.delete(); log_addr.delete(); log_cyc.delete();
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        tick();
        tick();
        n_checks++;
        if (log_data.size() != 2) begin
            n_fail++; $display("[TB] FAIL b2b_writes got %0d want 2", log_data.size());
        end else begin
            n_checks++;
            if (log_data[0] !== 32'h002081B3 || log_addr[0] != 1) begin
                n_fail++; $display("[TB] FAIL b2b_add got %h@%0d want 002081b3@1", log_data[0], log_addr[0]);
            end
            n_checks++;
            if (log_data[1] !== 32'h0020A423 || log_addr[1] != 2) begin
                n_fail++; $display("[TB] FAIL b2b_sw got %h@%0d want 0020a423@2", log_data[1], log_addr[1]);
            end
            n_checks++;
            if (log_cyc[1] - log_cyc[0] != 1) begin
                n_fail++; $display("[TB] FAIL b2b_gap got %0d want 1", log_cyc[1] - log_cyc[0]);
            end
        end
    endtask

    task automatic test_formats();
        int pulses;
        log_data.delete(); log_addr.delete(); log_cyc.delete();
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        wait_done(pulses);
        n_checks++;
        if (log_data.size() != 3) begin
            n_fail++; $display("[TB] FAIL fmt_writes got %0d want 3", log_data.size());
        end else begin
            n_checks++;
            if (log_data[0] !== 32'hFE208CE3 || log_addr[0] != 3) begin
                n_fail++; $display("[TB] FAIL fmt_beq got %h@%0d want fe208ce3@3", log_data[0], log_addr[0]);
            end
            n_checks++;
            if (log_data[1] !== 32'h001000EF || log_addr[1] != 4) begin
                n_fail++; $display("[TB] FAIL fmt_jal got %h@%0d want 001000ef@4", log_data[1], log_addr[1]);
            end
            n_checks++;
            if (log_data[2] !== 32'h123452B7 || log_addr[2] != 5) begin
                n_fail++; $display("[TB] FAIL fmt_lui got %h@%0d want 123452b7@5", log_data[2], log_addr[2]);
            end
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("[TB] FAIL fmt_done_pulses got %0d want 1", pulses); end
        n_checks++;
        if (b.count !== 11'd6) begin n_fail++; $display("[TB] FAIL fmt_count got %0d want 6", b.count); end
        n_checks++;
        if (b.err !== 2'b00 || b.busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL fmt_end err %b busy %b want 00 0", b.err, b.busy);
        end
    endtask

    task automatic test_range_errors();
        int pulses;
        log_data.delete(); log_addr.delete(); log_cyc.delete();
        pulse_start();
        n_checks++;
        if (b.count !== 11'd0 || b.err !== 2'b00) begin
            n_fail++; $display("[TB] FAIL restart_clear count %0d err %b want 0 00", b.count, b.err);
        end
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
        tick();
        n_checks++;
        if (b.err !== 2'b01) begin n_fail++; $display("[TB] FAIL range_err got %b want 01", b.err); end
        n_checks++;
        if (b.count !== 11'd0) begin n_fail++; $display("[TB] FAIL range_count got %0d want 0", b.count); end
        n_checks++;
        if (log_data.size() != 0) begin n_fail++; $display("[TB] FAIL range_nowrite got %0d want 0", log_data.size()); end
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        tick();
        n_checks++;
        if (log_data.size() != 1) begin
            n_fail++; $display("[TB] FAIL range_follow_writes got %0d want 1", log_data.size());
        end else if (log_data[0] !== 32'h00500093 || log_addr[0] != 0) begin
            n_fail++; $display("[TB] FAIL range_follow got %h@%0d want 00500093@0", log_data[0], log_addr[0]);
        end
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1);
        wait_done(pulses);
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("[TB] FAIL errlast_done got %0d want 1", pulses); end
        n_checks++;
        if (b.count !== 11'd1 || b.err !== 2'b01 || log_data.size() != 1) begin
            n_fail++; $display("[TB] FAIL errlast_state count %0d err %b writes %0d want 1 01 1",
                               b.count, b.err, log_data.size());
        end
    endtask

    task automatic test_overflow();
        int pulses;
        log4_addr.delete();
        pulses = 0;
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        b4.fmt = 3'd1; b4.opcode = 7'h13; b4.rd = 5'd1; b4.imm = 32'd5; b4.in_last = 1'b0;
        b4.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b4.done === 1'b1) pulses++;
        end
        b4.in_valid = 1'b0;
        n_checks++;
        if (log4_addr.size() != 4) begin
            n_fail++; $display("[TB] FAIL ovf_writes got %0d want 4", log4_addr.size());
        end else begin
            n_checks++;
            if (log4_addr[0] != 0 || log4_addr[3] != 3) begin
                n_fail++; $display("[TB] FAIL ovf_addrs got %0d..%0d want 0..3", log4_addr[0], log4_addr[3]);
            end
        end
        n_checks++;
        if (b4.err !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_err got %b want 10", b4.err); end
        n_checks++;
        if (b4.count !== 11'd4) begin n_fail++; $display("[TB] FAIL ovf_count got %0d want 4", b4.count); end
        n_checks++;
        if (b4.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_ready got %b want 0", b4.in_ready); end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("[TB] FAIL ovf_done got %0d want 1", pulses); end
    endtask

    task automatic test_abort();
        int n_before;
        int we_seen;
        pulse_start();
        set_tuple(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        b.in_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_before = log_data.size();
        we_seen  = 0;
        for (int i = 0; i < 5; i++) begin
            if (b.imem_we === 1'b1) we_seen++;
            tick();
        end
        b.in_valid = 1'b0;
        n_checks++;
        if (we_seen != 0 || log_data.size() != n_before) begin
            n_fail++; $display("[TB] FAIL abort_we got %0d strobes want 0", we_seen + log_data.size() - n_before);
        end
        n_checks++;
        if (b.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy got %b want 0", b.busy); end
        n_checks++;
        if (b.count !== 11'd0) begin n_fail++; $display("[TB] FAIL abort_count got %0d want 0", b.count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_formats();
        test_range_errors();
        test_overflow();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
